// File: rtl/conf_stream_loader.sv
// Purpose: decodes a 32-bit header/payload stream into single-cycle config writes (addr, ROMULTIC bits, data).
// Latency: last payload beat accepted at edge M -> o_we high for the cycle after M; o_done follows the final write.
// Backpressure: o_ready drops during WRITE and DONE (one bubble per data word); an idle i_valid stalls PAYLOAD indefinitely.
module conf_stream_loader #(
    parameter int IN_W   = 32,
    parameter int ADR_W  = 8,
    parameter int ROM_W  = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [IN_W-1:0]   i_word,
    output logic              o_we,
    output logic [ROM_W-1:0]  o_romultic_bits,
    output logic [ADR_W-1:0]  o_glb_adr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_abort
);

    localparam int BEATS = (DATA_W + IN_W - 1) / IN_W;
    localparam int ASM_W = BEATS * IN_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic             ready_r;
    logic [ADR_W-1:0] adr_cnt;
    logic [ROM_W-1:0] rom_q;
    logic [7:0]       cnt_q;
    logic [BCW-1:0]   beat_cnt;
    logic [ASM_W-1:0] asm_q;
    logic [ASM_W-1:0] full_w;
    logic             xfer;

    assign xfer = i_valid && ready_r;

    // Assembled word as it will look once the final beat currently on i_word lands in the top slot
    always_comb begin
        full_w = asm_q;
        full_w[(BEATS-1)*IN_W +: IN_W] = i_word;
    end

    // Burst sequencer: header decode, beat assembly, write strobe, completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            ready_r         <= 1'b0;
            adr_cnt         <= '0;
            rom_q           <= '0;
            cnt_q           <= '0;
            beat_cnt        <= '0;
            asm_q           <= '0;
            o_glb_adr       <= '0;
            o_romultic_bits <= '0;
            o_data          <= '0;
        end else if (i_abort && (state != IDLE)) begin
            // Any beat presented this cycle was already accepted by ready_r and is simply dropped
            state    <= IDLE;
            ready_r  <= 1'b1;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (xfer) begin
                        adr_cnt  <= i_word[ADR_W-1:0];
                        rom_q    <= i_word[ADR_W+ROM_W-1:ADR_W];
                        cnt_q    <= i_word[31:24];
                        beat_cnt <= '0;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat_cnt == BCW'(b)) begin
                                asm_q[b*IN_W +: IN_W] <= i_word;
                            end
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            // Outputs only move on entry to WRITE so they stay put between strobes
                            o_data          <= full_w[DATA_W-1:0];
                            o_glb_adr       <= adr_cnt;
                            o_romultic_bits <= rom_q;
                            beat_cnt        <= '0;
                            ready_r         <= 1'b0;
                            state           <= WRITE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    adr_cnt <= adr_cnt + 1'b1;
                    if (cnt_q == 8'd0) begin
                        state <= DONE;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                        ready_r <= 1'b1;
                        state   <= PAYLOAD;
                    end
                end
                DONE: begin
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = ready_r;
    assign o_we    = (state == WRITE);
    assign o_done  = (state == DONE);
    assign o_busy  = (state != IDLE);

endmodule
